// File: rtl/dio_mem_sched.sv
// dio_mem_sched: arbitrates UIO download writes, MIST DMA writes and SPI read
//   prefetches onto a single 16-bit word memory port (priority UIO > MIST > READ).
// Latency: toggle change -> mem_req after 2 cycles; mem_ack -> data_out after 1 cycle.
// Backpressure: one pending slot per source; an event for a still-pending slot is
//   dropped and raises the sticky overrun flag.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   strobe_uio, strobe_mist      write toggles; data_in (and uio_addr for UIO) valid on change
//   download                     UIO download active; rising edge clears overrun
//   out_strobe                   toggle: data_out consumed, prefetch next read word
//   dma_addr_load, dma_addr_in   pulse: reload DMA read/write pointers and prefetch
//   data_out                     prefetched read word
//   mem_req/we/addr/wdata        memory request, held until mem_ack
//   mem_ack, mem_rdata           single-cycle completion with read data
//   overrun                      sticky dropped-event flag
module dio_mem_sched #(
  parameter int ADDR_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  strobe_uio,
  input  logic                  strobe_mist,
  input  logic [15:0]           data_in,
  input  logic [ADDR_WIDTH-1:0] uio_addr,
  input  logic                  download,
  input  logic                  out_strobe,
  input  logic                  dma_addr_load,
  input  logic [ADDR_WIDTH-1:0] dma_addr_in,
  output logic [15:0]           data_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;
  typedef enum logic [1:0] {G_UIO = 2'd0, G_MIST = 2'd1, G_READ = 2'd2} gnt_t;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           dat;
  } wslot_t;

  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
  } rslot_t;

  state_t state, state_nxt;
  gnt_t   gnt, gnt_nxt;
  logic   grant;   // IDLE with something pending: launch an access on this edge
  logic   done;    // ACCESS completing on this edge

  wslot_t uio_slot, mist_slot;
  rslot_t rd_slot;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;

  logic tog_armed;
  logic uio_q, mist_q, out_q, download_q;
  logic rd_discard;

  // ---------------------------------------------------------------------------
  // Toggle detection. tog_armed stays low for the first edge after reset so the
  // registered copies pick up whatever level the inputs hold without an event.
  // ---------------------------------------------------------------------------
  logic uio_ev, mist_ev, out_ev, download_rise;

  assign uio_ev        = tog_armed & (strobe_uio ^ uio_q) & download;
  assign mist_ev       = tog_armed & (strobe_mist ^ mist_q);
  // a DMA reload retargets the read slot, so a coincident out_strobe is moot
  assign out_ev        = tog_armed & (out_strobe ^ out_q) & ~dma_addr_load;
  assign download_rise = tog_armed & download & ~download_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_armed  <= 1'b0;
      uio_q      <= 1'b0;
      mist_q     <= 1'b0;
      out_q      <= 1'b0;
      download_q <= 1'b0;
    end else begin
      tog_armed  <= 1'b1;
      uio_q      <= strobe_uio;
      mist_q     <= strobe_mist;
      out_q      <= out_strobe;
      download_q <= download;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot release on completion. A read whose slot was retargeted by a DMA
  // reload (earlier in the access or on the ack cycle itself) must leave the
  // slot valid: it now holds the new prefetch, not the completed read.
  // ---------------------------------------------------------------------------
  logic uio_clr, mist_clr, rd_clr, rd_keep;

  assign uio_clr  = done & (gnt == G_UIO);
  assign mist_clr = done & (gnt == G_MIST);
  assign rd_keep  = rd_discard | dma_addr_load;
  assign rd_clr   = done & (gnt == G_READ) & ~rd_keep;

  // A slot freed on this edge accepts a new event on the same edge.
  logic uio_busy, mist_busy, rd_busy;
  logic uio_drop, mist_drop, rd_drop;

  assign uio_busy  = uio_slot.vld  & ~uio_clr;
  assign mist_busy = mist_slot.vld & ~mist_clr;
  assign rd_busy   = rd_slot.vld   & ~rd_clr;

  assign uio_drop  = uio_ev  & uio_busy;
  assign mist_drop = mist_ev & mist_busy;
  assign rd_drop   = out_ev  & rd_busy;

  // ---------------------------------------------------------------------------
  // Pending slots and DMA pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uio_slot  <= '0;
      mist_slot <= '0;
      rd_slot   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (uio_ev && !uio_busy) begin
        uio_slot <= '{vld: 1'b1, addr: uio_addr, dat: data_in};
      end else if (uio_clr) begin
        uio_slot.vld <= 1'b0;
      end

      if (mist_ev && !mist_busy) begin
        mist_slot <= '{vld: 1'b1, addr: wr_ptr, dat: data_in};
      end else if (mist_clr) begin
        mist_slot.vld <= 1'b0;
      end

      if (dma_addr_load) begin
        wr_ptr <= dma_addr_in;
      end else if (mist_ev && !mist_busy) begin
        wr_ptr <= wr_ptr + ADDR_ONE;
      end

      // the reload always wins the read slot and pre-advances rd_ptr past
      // the prefetch address
      if (dma_addr_load) begin
        rd_slot <= '{vld: 1'b1, addr: dma_addr_in};
        rd_ptr  <= dma_addr_in + ADDR_ONE;
      end else if (out_ev && !rd_busy) begin
        rd_slot <= '{vld: 1'b1, addr: rd_ptr};
        rd_ptr  <= rd_ptr + ADDR_ONE;
      end else if (rd_clr) begin
        rd_slot.vld <= 1'b0;
      end
    end
  end

  // Sticky overrun: a fresh drop outranks a clear on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (uio_drop || mist_drop || rd_drop) begin
      overrun <= 1'b1;
    end else if (dma_addr_load || download_rise) begin
      overrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      gnt   <= G_UIO;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    grant     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (uio_slot.vld || mist_slot.vld || rd_slot.vld) begin
          grant     = 1'b1;
          state_nxt = S_ACCESS;
          if (uio_slot.vld)       gnt_nxt = G_UIO;
          else if (mist_slot.vld) gnt_nxt = G_MIST;
          else                    gnt_nxt = G_READ;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory port: registered, so everything is stable for the whole request.
  // Returning to IDLE on ack guarantees a low cycle between requests.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant) begin
      mem_req <= 1'b1;
      case (gnt_nxt)
        G_UIO: begin
          mem_we    <= 1'b1;
          mem_addr  <= uio_slot.addr;
          mem_wdata <= uio_slot.dat;
        end
        G_MIST: begin
          mem_we    <= 1'b1;
          mem_addr  <= mist_slot.addr;
          mem_wdata <= mist_slot.dat;
        end
        default: begin
          // a reload on the grant edge redirects the read to the new address
          mem_we   <= 1'b0;
          mem_addr <= dma_addr_load ? dma_addr_in : rd_slot.addr;
        end
      endcase
    end else if (done) begin
      mem_req <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return. A reload during an in-flight read marks its data stale; the
  // slot already carries the replacement prefetch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_discard <= 1'b0;
      data_out   <= '0;
    end else begin
      if (done) begin
        rd_discard <= 1'b0;
      end else if (dma_addr_load && state == S_ACCESS && gnt == G_READ) begin
        rd_discard <= 1'b1;
      end

      if (done && gnt == G_READ && !rd_keep) begin
        data_out <= mem_rdata;
      end
    end
  end

endmodule
